// File: rtl/pi_request_queue.sv
// -----------------------------------------------------------------------------
// pi_request_queue
//
// Pi-side command front end for the 68000 bus-cycle engine. The Pi writes
// staging registers (data lo/hi, address lo) and then a commit register that
// carries the address high byte plus the cycle attributes. Each commit pushes a
// complete request into a small in-order FIFO. The head request is offered to
// the bus engine over a valid/ready handshake; after acceptance the block waits
// for the engine's completion pulse before offering the next one. Read results
// are latched for the Pi until it acknowledges them.
//
// Ports:
//   sys_clk, sys_rst          clock, synchronous active-high reset
//   pi_wr_strobe/reg/wdata    Pi register write (already in sys_clk domain)
//   pi_rd_ack                 Pi has consumed res_data
//   cmd_valid/ready           request handshake to the bus engine
//   cmd_addr/size/read/fc/wdata  request fields (from the FIFO head)
//   done_strobe, done_data    bus cycle completion and read data
//   res_data, res_valid       latched read result
//   req_busy                  anything queued or in flight (GPIO3)
//   queue_full, queue_level   FIFO status
//   overflow                  sticky: a commit was dropped on a full FIFO
// -----------------------------------------------------------------------------
module pi_request_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 24
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     pi_wr_strobe,
    input  logic [2:0]               pi_reg,
    input  logic [15:0]              pi_wdata,
    input  logic                     pi_rd_ack,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [ADDR_W-1:0]        cmd_addr,
    output logic [1:0]               cmd_size,
    output logic                     cmd_read,
    output logic [2:0]               cmd_fc,
    output logic [31:0]              cmd_wdata,
    input  logic                     done_strobe,
    input  logic [31:0]              done_data,
    output logic [31:0]              res_data,
    output logic                     res_valid,
    output logic                     req_busy,
    output logic                     queue_full,
    output logic [$clog2(DEPTH):0]   queue_level,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [2:0]        fc;
        logic              read;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } req_t;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT_DONE
    } state_t;

    // Staging registers
    logic [31:0]  r_data;
    logic [15:0]  r_addr_lo;

    // FIFO
    req_t         r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]  r_count;

    // Control / status
    state_t       r_state;
    logic         r_rec_read;
    logic [31:0]  r_res_data;
    logic         r_res_valid;
    logic         r_overflow;
    logic         r_busy;

    // Combinational
    state_t       w_state_nxt;
    logic         w_cmd_valid;
    logic         w_load_res;
    logic         w_commit;
    logic         w_ovf_clr;
    logic         w_empty;
    logic         w_full;
    logic         w_pop;
    logic         w_push;
    logic         w_drop;
    logic [PW:0]  w_count_nxt;
    logic [23:0]  w_commit_addr;
    req_t         w_head;
    req_t         w_new;

    assign w_commit      = pi_wr_strobe && (pi_reg == 3'd3);
    assign w_ovf_clr     = pi_wr_strobe && (pi_reg == 3'd7) && pi_wdata[0];
    assign w_empty       = (r_count == '0);
    assign w_full        = (r_count == (PW+1)'(DEPTH));
    assign w_head        = r_mem[r_rd_ptr];

    assign w_commit_addr = {pi_wdata[7:0], r_addr_lo};
    assign w_new.fc      = pi_wdata[13:11];
    assign w_new.read    = pi_wdata[10];
    assign w_new.size    = pi_wdata[9:8];
    assign w_new.addr    = ADDR_W'(w_commit_addr);
    assign w_new.data    = r_data;

    assign w_pop         = w_cmd_valid && cmd_ready;
    // A full FIFO still takes a commit when the head leaves in the same cycle.
    assign w_push        = w_commit && (!w_full || w_pop);
    assign w_drop        = w_commit && !w_push;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + (PW+1)'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - (PW+1)'(1);
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= ST_IDLE;
            r_rec_read <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_rec_read <= w_head.read;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_valid = 1'b0;
        w_load_res  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A read at the head waits for the previous result to be taken,
                // which also holds back everything queued behind it.
                w_cmd_valid = !w_empty && !(w_head.read && r_res_valid);
                if (w_cmd_valid && cmd_ready) begin
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (done_strobe) begin
                    w_state_nxt = ST_IDLE;
                    w_load_res  = r_rec_read;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- staging
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_data    <= '0;
            r_addr_lo <= '0;
        end else if (pi_wr_strobe) begin
            case (pi_reg)
                3'd0:    r_data[15:0]  <= pi_wdata;
                3'd1:    r_data[31:16] <= pi_wdata;
                3'd2:    r_addr_lo     <= pi_wdata;
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------- FIFO
    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_new;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // ---------------------------------------------------------------- status
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (w_load_res) begin
                r_res_data  <= done_data;
                r_res_valid <= 1'b1;
            end else if (pi_rd_ack) begin
                r_res_valid <= 1'b0;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end

            // Built from next-state values so it tracks the cycle after the
            // commit / final completion rather than lagging a further cycle.
            r_busy <= (w_count_nxt != '0) || (w_state_nxt == ST_WAIT_DONE);
        end
    end

    // ---------------------------------------------------------------- outputs
    assign cmd_valid   = w_cmd_valid;
    assign cmd_addr    = w_empty ? '0 : w_head.addr;
    assign cmd_size    = w_empty ? '0 : w_head.size;
    assign cmd_read    = w_empty ? 1'b0 : w_head.read;
    assign cmd_fc      = w_empty ? '0 : w_head.fc;
    assign cmd_wdata   = w_empty ? '0 : w_head.data;
    assign res_data    = r_res_data;
    assign res_valid   = r_res_valid;
    assign req_busy    = r_busy;
    assign queue_full  = w_full;
    assign queue_level = r_count;
    assign overflow    = r_overflow;

endmodule
